// File: rtl/fsk_demodulator.sv
// FSK receive path: synchronizes the tone decision and carrier flag, samples mid-symbol,
// majority-votes repetition_factor samples per bit and assembles a DATA_WIDTH-bit word (MSB first).
module fsk_demodulator #(
  parameter int DATA_WIDTH  = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  fsk_in,
  input  logic                  carrier_in,
  input  logic [15:0]           symbol_time,
  input  logic [3:0]            repetition_factor,
  output logic [DATA_WIDTH-1:0] out_bitstream,
  output logic                  out_valid,
  output logic                  abort,
  output logic                  busy,
  output logic [15:0]           disagree_count,
  output logic [1:0]            dbg_state
);

  // Handshake: out_valid and abort are single-cycle strobes with no backpressure;
  // out_bitstream is stable from the out_valid cycle until the next out_valid.

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  fsk_sync_q, car_sync_q;
  logic                    car_prev_q;
  logic [SW-1:0]           settle_q;
  logic [15:0]             sym_t_q, sym_t_d;
  logic [3:0]              rep_q, rep_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [3:0]              samp_q, samp_d;
  logic [3:0]              ones_q, ones_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [15:0]             dis_q, dis_d;
  logic                    abort_q, abort_d;

  logic        fsk_s, car_s, settled, car_rise;
  logic [4:0]  ones_n;
  logic        bit_v;
  logic [3:0]  miss;
  logic [16:0] dis_sum;
  logic [15:0] dis_sat;

  assign fsk_s    = fsk_sync_q[SYNC_STAGES-1];
  assign car_s    = car_sync_q[SYNC_STAGES-1];
  // Edge detection is held off until the synchronizer has flushed its reset zeros,
  // so a carrier already present at reset release is not mistaken for a new frame.
  assign settled  = (settle_q == SW'(SYNC_STAGES));
  assign car_rise = settled && car_s && !car_prev_q;

  assign ones_n  = {1'b0, ones_q} + {4'b0, fsk_s};
  assign bit_v   = ({ones_n, 1'b0} > {2'b0, rep_q});
  assign miss    = bit_v ? (rep_q - ones_n[3:0]) : ones_n[3:0];
  assign dis_sum = {1'b0, dis_q} + {13'b0, miss};
  assign dis_sat = dis_sum[16] ? 16'hFFFF : dis_sum[15:0];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      fsk_sync_q <= '0;
      car_sync_q <= '0;
      car_prev_q <= 1'b1;
      settle_q   <= '0;
      sym_t_q    <= '0;
      rep_q      <= '0;
      cnt_q      <= '0;
      samp_q     <= '0;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      out_q      <= '0;
      dis_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fsk_sync_q <= {fsk_sync_q[SYNC_STAGES-2:0], fsk_in};
      car_sync_q <= {car_sync_q[SYNC_STAGES-2:0], carrier_in};
      if (settled) car_prev_q <= car_s;
      else         settle_q   <= settle_q + 1'b1;
      sym_t_q    <= sym_t_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      dis_q      <= dis_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sym_t_d   = sym_t_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    ones_d    = ones_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    out_d     = out_q;
    dis_d     = dis_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (car_rise) begin
          sym_t_d   = (symbol_time < 16'd2) ? 16'd2 : symbol_time;
          rep_d     = (repetition_factor == 4'd0) ? 4'd1 : repetition_factor;
          cnt_d     = (sym_t_d >> 1) - 16'd1;
          samp_d    = '0;
          ones_d    = '0;
          bit_cnt_d = '0;
          dis_d     = '0;
          state_d   = ALIGN;
        end
      end
      ALIGN, SAMPLE: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = sym_t_q - 16'd1;
          state_d = SAMPLE;
          if (samp_q == rep_q - 4'd1) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], bit_v};
            dis_d     = dis_sat;
            samp_d    = '0;
            ones_d    = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
              out_d   = shift_d;
              state_d = DONE;
            end
          end else begin
            samp_d = samp_q + 4'd1;
            ones_d = ones_n[3:0];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
        // A final sample coinciding with carrier loss still completes the frame.
        if (!car_s && state_d != DONE) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_bitstream  = out_q;
  assign out_valid      = (state_q == DONE);
  assign abort          = abort_q;
  assign busy           = (state_q != IDLE);
  assign disagree_count = dis_q;
  assign dbg_state      = state_q;

endmodule
